// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter: round-robin owner of data RAM port B with optional post-reset clear sweep
// Shares port B between req0 (debug/host loader) and req1 (display/peripheral scanner).
// At most one access is issued per cycle, and read data arrives one cycle after the grant.
// Optional feature macro: RAM_PORTB_CLEAR_EN. When it is defined, the whole RAM is zeroed
// after reset, before any grant is issued.
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   reqN/weN/addrN/wdataN      requester command, held stable until gntN
//   gntN                       command issued to RAM this cycle (combinational)
//   rvalidN, rdata             read data for requester N, one cycle after a read grant
//   ram_address_b/ram_data_b/ram_wren_b/ram_q_b   RAM port B
//   clear_busy                 clear sweep in progress
module ram_portb_arbiter #(
   parameter int DATA_WIDTH         = 16,
   parameter int RAM_REGISTER_COUNT = 2**10
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic                                  req0,
   input  logic                                  we0,
   input  logic [$clog2(RAM_REGISTER_COUNT)-1:0] addr0,
   input  logic [DATA_WIDTH-1:0]                 wdata0,
   input  logic                                  req1,
   input  logic                                  we1,
   input  logic [$clog2(RAM_REGISTER_COUNT)-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]                 wdata1,
   output logic                                  gnt0,
   output logic                                  gnt1,
   output logic                                  rvalid0,
   output logic                                  rvalid1,
   output logic [DATA_WIDTH-1:0]                 rdata,
   output logic [$clog2(RAM_REGISTER_COUNT)-1:0] ram_address_b,
   output logic [DATA_WIDTH-1:0]                 ram_data_b,
   output logic                                  ram_wren_b,
   input  logic [DATA_WIDTH-1:0]                 ram_q_b,
   output logic                                  clear_busy
);
   localparam int ADDR_W = $clog2(RAM_REGISTER_COUNT);
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] ARB   = 1'b1;
   logic [0:0]        state;
   logic              rr_last;
   logic              rvalid0_q;
   logic              rvalid1_q;
   logic [ADDR_W-1:0] clear_ptr;
   logic              clear_last;
`ifdef RAM_PORTB_CLEAR_EN
   localparam logic [0:0] RESET_STATE = CLEAR;
   // One extra bit so the sweep ends cleanly when the depth is a full power of two
   logic [ADDR_W:0] clear_addr;
   always_ff @(posedge Clk) begin
      if (Reset) clear_addr <= '0;
      else if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
   end
   assign clear_ptr  = clear_addr[ADDR_W-1:0];
   assign clear_last = clear_addr == (ADDR_W+1)'(RAM_REGISTER_COUNT - 1);
`else
   localparam logic [0:0] RESET_STATE = ARB;
   assign clear_ptr  = '0;
   assign clear_last = 1'b0;
`endif
   always_comb begin
      gnt0          = 1'b0;
      gnt1          = 1'b0;
      ram_address_b = '0;
      ram_data_b    = '0;
      ram_wren_b    = 1'b0;
      clear_busy    = 1'b0;
      if (!Reset && state == CLEAR) begin
         ram_address_b = clear_ptr;
         ram_wren_b    = 1'b1;
         clear_busy    = 1'b1;
      end else if (!Reset) begin
         // rr_last==1 means req1 was served last, so req0 wins a tie
         gnt0          = req0 && (!req1 || rr_last);
         gnt1          = req1 && !gnt0;
         ram_address_b = gnt0 ? addr0 : gnt1 ? addr1 : '0;
         ram_data_b    = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
         ram_wren_b    = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= RESET_STATE;
         rr_last   <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state     <= (state == CLEAR && clear_last) ? ARB : state;
         rr_last   <= gnt0 ? 1'b0 : gnt1 ? 1'b1 : rr_last;
         rvalid0_q <= gnt0 && !we0;
         rvalid1_q <= gnt1 && !we1;
      end
   end
   // Gated so a read granted just before reset never reports data while reset is held
   assign rvalid0 = rvalid0_q && !Reset;
   assign rvalid1 = rvalid1_q && !Reset;
   assign rdata   = ram_q_b;
endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb_ram_portb_arbiter: directed scoreboard bench for ram_portb_arbiter with a behavioural port-B RAM
module tb_ram_portb_arbiter;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [9:0]  addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, ram_wren_b, clear_busy;
   logic [15:0] rdata, ram_data_b, ram_q_b;
   logic [9:0]  ram_address_b;
   logic [15:0] mem [1024];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   typedef struct {int cyc; logic port; logic [15:0] data;} exp_t;
   exp_t        q [$];

   ram_portb_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
      .ram_q_b(ram_q_b), .clear_busy(clear_busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
      ram_q_b <= mem[ram_address_b];
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (rvalid0 || rvalid1) begin
         if (q.size() == 0) begin
            chk("spurious_rvalid", {30'b0, rvalid0, rvalid1}, 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rvalid_port", {30'b0, rvalid0, rvalid1}, e.port ? 32'h1 : 32'h2);
            chk("rdata", {16'b0, rdata}, {16'b0, e.data});
            chk("rvalid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input string nm,
                        input logic r0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [9:0] a1, input logic [15:0] d1,
                        input logic eg0, input logic eg1, input logic [15:0] ex);
      @(negedge Clk);
      Reset = 1'b0;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      chk({nm, "_gnt"}, {30'b0, gnt0, gnt1}, {30'b0, eg0, eg1});
      chk({nm, "_busy"}, {31'b0, clear_busy}, 32'h0);
      if (eg0 || eg1)
         chk({nm, "_bus"}, {5'b0, ram_wren_b, ram_address_b, ram_data_b},
             eg0 ? {5'b0, w0, a0, d0} : {5'b0, w1, a1, d1});
      else
         chk({nm, "_wren"}, {31'b0, ram_wren_b}, 32'h0);
      if ((eg0 && !w0) || (eg1 && !w1)) q.push_back('{cyc + 1, eg1, ex});
   endtask

   task automatic reset_cycle();
      @(negedge Clk);
      Reset = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 10'h155; wdata0 = 16'hFFFF;
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'h2AA; wdata1 = 16'hFFFF;
      #1;
      chk("reset_outputs", {gnt0, gnt1, ram_wren_b, clear_busy, rvalid0, rvalid1, ram_address_b, ram_data_b},
          32'h0);
   endtask

`ifdef RAM_PORTB_CLEAR_EN
   task automatic clear_run(input int stop_at);
      for (int i = 0; i < 1024; i++) begin
         if (i == stop_at) break;
         @(negedge Clk);
         Reset = 1'b0;
         req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5; wdata0 = 16'h0;
         req1 = 1'b1; we1 = 1'b0; addr1 = 10'd6; wdata1 = 16'h0;
         #1;
         chk("clear_sweep", {clear_busy, ram_wren_b, gnt0, gnt1, ram_address_b, ram_data_b},
             {4'b1100, 10'(i), 16'h0});
      end
   endtask
`endif

   initial begin
`ifdef RAM_PORTB_CLEAR_EN
      for (int i = 0; i < 1024; i++) mem[i] = 16'hA5A5;
`else
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
`endif
      ram_q_b = '0;
      reset_cycle();
      reset_cycle();
`ifdef RAM_PORTB_CLEAR_EN
      clear_run(300);
      reset_cycle();
      clear_run(-1);
      issue("clr_read5", 1, 0, 10'd5, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'h0000);
`else
      issue("release_idle", 0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, 0, 0, 16'h0);
`endif
      issue("first_r1_read", 0, 0, 10'd0, 16'h0, 1, 0, 10'd5, 16'h0, 0, 1, 16'h0000);
      issue("wr_beef", 1, 1, 10'h010, 16'hBEEF, 0, 0, 10'd0, 16'h0, 1, 0, 16'h0);
      issue("rd_beef", 1, 0, 10'h010, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'hBEEF);
      issue("wr_1234", 0, 0, 10'd0, 16'h0, 1, 1, 10'h3FF, 16'h1234, 0, 1, 16'h0);
      issue("rd_1234", 1, 0, 10'h3FF, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'h1234);
      issue("wr_1111", 1, 1, 10'h020, 16'h1111, 0, 0, 10'd0, 16'h0, 1, 0, 16'h0);
      issue("wr_2222", 0, 0, 10'd0, 16'h0, 1, 1, 10'h021, 16'h2222, 0, 1, 16'h0);
      for (int k = 0; k < 4; k++)
         issue("contend", 1, 0, 10'h020, 16'h0, 1, 0, 10'h021, 16'h0,
               (k % 2) == 0, (k % 2) == 1, (k % 2) == 0 ? 16'h1111 : 16'h2222);
      issue("r0_only", 1, 0, 10'h021, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'h2222);
      issue("tie_after_r0", 1, 0, 10'h020, 16'h0, 1, 0, 10'h021, 16'h0, 0, 1, 16'h2222);
      issue("r0_pending", 1, 0, 10'h020, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'h1111);
      issue("idle", 0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, 0, 0, 16'h0);
      reset_cycle();
`ifdef RAM_PORTB_CLEAR_EN
      clear_run(-1);
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
      mem[10'h010] = 16'hBEEF;
      mem[10'h3FF] = 16'h1234;
`else
      issue("release_idle2", 0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, 0, 0, 16'h0);
`endif
      issue("rr_after_reset", 1, 0, 10'h010, 16'h0, 1, 0, 10'h3FF, 16'h0, 1, 0, 16'hBEEF);
      issue("rr_second", 1, 0, 10'h010, 16'h0, 1, 0, 10'h3FF, 16'h0, 0, 1, 16'h1234);
      for (int k = 0; k < 3; k++)
         issue("drain", 0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, 0, 0, 16'h0);
      chk("scoreboard_empty", q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
